// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
//   fr_state_e     : controller FSM states (run, pending replay, shadow squash)
//   redirect_cls_e : redirect class; numeric order encodes priority (trap highest)
//   PC_RESET_VEC   : PC reset vector, owned by the PC register, kept here for reference
package fetch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StPending = 2'd1,
        StShadow  = 2'd2
    } fr_state_e;

    // Encoding is significant: a larger value means a higher priority.
    typedef enum logic [1:0] {
        ClsNone   = 2'd0,
        ClsBranch = 2'd1,
        ClsMret   = 2'd2,
        ClsTrap   = 2'd3
    } redirect_cls_e;

    localparam logic [31:0] PC_RESET_VEC = 32'h8000_0000;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_arbiter.sv
// Combinational priority selection of the live redirect source.
// Ports:
//   trap_req / trap_vec   : trap request and mtvec (low two bits are forced to zero)
//   mret_req / mepc       : mret retiring and its return address
//   br_taken / br_target  : EX-stage resolved-taken branch and its target
//   live_cls / live_addr  : winning class (ClsNone if nothing live) and its address
module redirect_arbiter
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             trap_req,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             mret_req,
    input  logic [WIDTH-1:0] mepc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output redirect_cls_e    live_cls,
    output logic [WIDTH-1:0] live_addr
);

    always_comb begin
        live_cls  = ClsNone;
        live_addr = '0;
        if (trap_req) begin
            live_cls  = ClsTrap;
            live_addr = {trap_vec[WIDTH-1:2], 2'b00};
        end else if (mret_req) begin
            live_cls  = ClsMret;
            live_addr = mepc;
        end else if (br_taken) begin
            live_cls  = ClsBranch;
            live_addr = br_target;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates trap/mret/branch redirects, holds a redirect
// that arrives while the memories freeze the pipeline and replays it once the freeze
// drops, squashes the wrong-path fetch after a redirect, and counts stalls/redirects.
// Ports:
//   cpu_clk, reset                    : clock, async active-high reset
//   br_taken/br_target, trap_req/trap_vec, mret_req/mepc : redirect sources
//   load_use                          : ID-stage load-use hazard
//   imem_busy, dmem_busy              : memory not ready (either one freezes the pipe)
//   count_enb, pcsel, redirect_addr   : PC control
//   flush_ifid, flush_idex, stall_ifid, stall_idex : pipeline register control
//   stall_cnt, redirect_cnt           : free-running wrapping performance counters
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             trap_req,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             mret_req,
    input  logic [WIDTH-1:0] mepc,
    input  logic             load_use,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             count_enb,
    output logic             pcsel,
    output logic [WIDTH-1:0] redirect_addr,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      redirect_cnt
);

    fr_state_e        state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    redirect_cls_e    pend_cls_q, pend_cls_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]      stall_cnt_q, redirect_cnt_q;

    redirect_cls_e    live_cls;
    logic [WIDTH-1:0] live_addr;
    logic             freeze;
    logic             live_wins;

    assign freeze = imem_busy | dmem_busy;

    redirect_arbiter #(
        .WIDTH (WIDTH)
    ) u_arbiter (
        .trap_req  (trap_req),
        .trap_vec  (trap_vec),
        .mret_req  (mret_req),
        .mepc      (mepc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .live_cls  (live_cls),
        .live_addr (live_addr)
    );

    // A live redirect only displaces a held one if strictly higher priority.
    assign live_wins = !pend_valid_q || (live_cls > pend_cls_q);

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_cls_d    = pend_cls_q;
        pend_addr_d   = pend_addr_q;
        count_enb     = 1'b1;
        pcsel         = 1'b0;
        redirect_addr = live_addr;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        stall_ifid    = 1'b0;
        stall_idex    = 1'b0;

        if (freeze) begin
            count_enb  = 1'b0;
            stall_ifid = 1'b1;
            stall_idex = 1'b1;
            if (live_cls != ClsNone) begin
                if (state_q != StPending || live_wins) begin
                    pend_valid_d = 1'b1;
                    pend_cls_d   = live_cls;
                    pend_addr_d  = live_addr;
                end
                state_d = StPending;
            end
        end else begin
            unique case (state_q)
                StPending: begin
                    count_enb     = 1'b1;
                    pcsel         = 1'b1;
                    flush_ifid    = 1'b1;
                    flush_idex    = 1'b1;
                    redirect_addr = live_wins ? live_addr : pend_addr_q;
                    pend_valid_d  = 1'b0;
                    pend_cls_d    = ClsNone;
                    pend_addr_d   = '0;
                    state_d       = StShadow;
                end
                StShadow: begin
                    if (live_cls != ClsNone) begin
                        pcsel      = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = StShadow;
                    end else begin
                        // Instruction fetched down the old path is still in IF/ID.
                        flush_ifid = 1'b1;
                        state_d    = StRun;
                    end
                end
                default: begin
                    if (live_cls != ClsNone) begin
                        pcsel      = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = StShadow;
                    end else if (load_use) begin
                        count_enb  = 1'b0;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q        <= StRun;
            pend_valid_q   <= 1'b0;
            pend_cls_q     <= ClsNone;
            pend_addr_q    <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_cls_q   <= pend_cls_d;
            pend_addr_q  <= pend_addr_d;
            if (!count_enb) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pcsel) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl.
// Control outputs are compared as a packed vector
// {count_enb, pcsel, flush_ifid, flush_idex, stall_ifid, stall_idex}.
module tb_fetch_redirect_ctrl;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        br_taken, trap_req, mret_req, load_use, imem_busy, dmem_busy;
    logic [31:0] br_target, trap_vec, mepc;
    logic        count_enb, pcsel, flush_ifid, flush_idex, stall_ifid, stall_idex;
    logic [31:0] redirect_addr, stall_cnt, redirect_cnt;
    logic [5:0]  ctl;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] CtlRun    = 6'b100000;
    localparam logic [5:0] CtlRedir  = 6'b111100;
    localparam logic [5:0] CtlSquash = 6'b101000;
    localparam logic [5:0] CtlLdUse  = 6'b000110;
    localparam logic [5:0] CtlFreeze = 6'b000011;

    always #5 cpu_clk = ~cpu_clk;

    assign ctl = {count_enb, pcsel, flush_ifid, flush_idex, stall_ifid, stall_idex};

    fetch_redirect_ctrl #(
        .WIDTH (32)
    ) dut (
        .cpu_clk       (cpu_clk),
        .reset         (reset),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .trap_req      (trap_req),
        .trap_vec      (trap_vec),
        .mret_req      (mret_req),
        .mepc          (mepc),
        .load_use      (load_use),
        .imem_busy     (imem_busy),
        .dmem_busy     (dmem_busy),
        .count_enb     (count_enb),
        .pcsel         (pcsel),
        .redirect_addr (redirect_addr),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .stall_ifid    (stall_ifid),
        .stall_idex    (stall_idex),
        .stall_cnt     (stall_cnt),
        .redirect_cnt  (redirect_cnt)
    );

    task automatic quiet_inputs();
        br_taken  = 1'b0;
        trap_req  = 1'b0;
        mret_req  = 1'b0;
        load_use  = 1'b0;
        imem_busy = 1'b0;
        dmem_busy = 1'b0;
        br_target = 32'h0;
        trap_vec  = 32'h0;
        mepc      = 32'h0;
    endtask

    // Leaves time just after a rising edge, ready to drive the next cycle's inputs.
    task automatic do_reset();
        quiet_inputs();
        reset = 1'b1;
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        quiet_inputs();
        reset = 1'b1;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRun) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want %b", ctl, CtlRun);
        end
        n_tests++;
        if (stall_cnt !== 32'd0 || redirect_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, redirect_cnt);
        end
        next_cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_branch();
        do_reset();
        br_taken  = 1'b1;
        br_target = 32'h8000_0040;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRedir || redirect_addr !== 32'h8000_0040) begin
            n_fail++;
            $display("FAIL branch_redirect: got %b %h want %b 80000040", ctl, redirect_addr,
                     CtlRedir);
        end
        next_cycle();
        br_taken = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlSquash) begin
            n_fail++;
            $display("FAIL branch_shadow: got %b want %b", ctl, CtlSquash);
        end
        n_tests++;
        if (redirect_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL branch_redirect_cnt: got %0d want 1", redirect_cnt);
        end
        next_cycle();
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRun || stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL branch_back_to_run: got %b cnt %0d want %b cnt 0", ctl, stall_cnt,
                     CtlRun);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use = 1'b1;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlLdUse) begin
            n_fail++;
            $display("FAIL load_use_ctl: got %b want %b", ctl, CtlLdUse);
        end
        next_cycle();
        load_use = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (stall_cnt !== 32'd1 || ctl !== CtlRun) begin
            n_fail++;
            $display("FAIL load_use_after: got cnt %0d ctl %b want 1 %b", stall_cnt, ctl, CtlRun);
        end
    endtask

    task automatic test_freeze_branch();
        do_reset();
        dmem_busy = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h8000_0100;
        for (int c = 1; c <= 3; c++) begin
            @(negedge cpu_clk);
            n_tests++;
            if (ctl !== CtlFreeze) begin
                n_fail++;
                $display("FAIL freeze_cycle%0d: got %b want %b", c, ctl, CtlFreeze);
            end
            next_cycle();
            br_taken = 1'b0;
        end
        dmem_busy = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRedir || redirect_addr !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL freeze_replay: got %b %h want %b 80000100", ctl, redirect_addr,
                     CtlRedir);
        end
        n_tests++;
        if (stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL freeze_stall_cnt: got %0d want 3", stall_cnt);
        end
        next_cycle();
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlSquash || redirect_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL freeze_shadow: got %b cnt %0d want %b cnt 1", ctl, redirect_cnt,
                     CtlSquash);
        end
    endtask

    task automatic test_pending_overwrite();
        do_reset();
        imem_busy = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h8000_0100;
        next_cycle();
        br_taken = 1'b0;
        trap_req = 1'b1;
        trap_vec = 32'h8000_0203;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlFreeze) begin
            n_fail++;
            $display("FAIL pending_frozen: got %b want %b", ctl, CtlFreeze);
        end
        next_cycle();
        // Lower-priority branch while a trap is held must be ignored.
        trap_req  = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h8000_0300;
        next_cycle();
        br_taken  = 1'b0;
        imem_busy = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRedir || redirect_addr !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL pending_overwrite: got %b %h want %b 80000200", ctl, redirect_addr,
                     CtlRedir);
        end
    endtask

    task automatic test_priority();
        do_reset();
        trap_req  = 1'b1;
        trap_vec  = 32'h8000_1001;
        mret_req  = 1'b1;
        mepc      = 32'h8000_2000;
        br_taken  = 1'b1;
        br_target = 32'h8000_3000;
        load_use  = 1'b1;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRedir || redirect_addr !== 32'h8000_1000) begin
            n_fail++;
            $display("FAIL prio_trap: got %b %h want %b 80001000", ctl, redirect_addr, CtlRedir);
        end
        next_cycle();
        trap_req = 1'b0;
        load_use = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRedir || redirect_addr !== 32'h8000_2000) begin
            n_fail++;
            $display("FAIL prio_mret: got %b %h want %b 80002000", ctl, redirect_addr, CtlRedir);
        end
        next_cycle();
        mret_req = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRedir || redirect_addr !== 32'h8000_3000) begin
            n_fail++;
            $display("FAIL prio_branch: got %b %h want %b 80003000", ctl, redirect_addr,
                     CtlRedir);
        end
        next_cycle();
        br_taken = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlSquash || redirect_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL prio_tail: got %b cnt %0d want %b cnt 3", ctl, redirect_cnt,
                     CtlSquash);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        dmem_busy = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h8000_0500;
        next_cycle();
        br_taken = 1'b0;
        next_cycle();
        reset = 1'b1;
        #1;
        n_tests++;
        if (stall_cnt !== 32'd0 || redirect_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_pend_async: got %0d/%0d want 0/0", stall_cnt, redirect_cnt);
        end
        dmem_busy = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRun) begin
            n_fail++;
            $display("FAIL rst_pend_during: got %b want %b", ctl, CtlRun);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge cpu_clk);
        n_tests++;
        if (ctl !== CtlRun) begin
            n_fail++;
            $display("FAIL rst_pend_no_replay: got %b want %b", ctl, CtlRun);
        end
        next_cycle();
        @(negedge cpu_clk);
        n_tests++;
        if (redirect_cnt !== 32'd0 || ctl !== CtlRun) begin
            n_fail++;
            $display("FAIL rst_pend_after: got cnt %0d ctl %b want 0 %b", redirect_cnt, ctl,
                     CtlRun);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_use();
        test_freeze_branch();
        test_pending_overwrite();
        test_priority();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address width of all target and redirect buses.
REQ-002 SHALL have port cpu_clk  in  1  pipeline clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port br_taken  in  1  EX-stage branch/jump resolved taken; br_target  in  WIDTH  its target.
REQ-005 SHALL have port trap_req  in  1  trap raised this cycle; trap_vec  in  WIDTH  mtvec value.
REQ-006 SHALL have port mret_req  in  1  mret retiring; mepc  in  WIDTH  return address.
REQ-007 SHALL have port load_use  in  1  ID-stage load-use hazard detected.
REQ-008 SHALL have ports imem_busy and dmem_busy  in  1 each  memory not ready; freeze = imem_busy | dmem_busy.
REQ-009 SHALL have port count_enb  out  1  PC advance enable.
REQ-010 SHALL have port pcsel  out  1  PC loads redirect_addr instead of PC+4.
REQ-011 SHALL have port redirect_addr  out  WIDTH  PC load value.
REQ-012 SHALL have ports flush_ifid, flush_idex, stall_ifid, stall_idex  out  1 each  pipeline register control.
REQ-013 SHALL have ports stall_cnt and redirect_cnt  out  32 each  performance counters.

Function
REQ-014 SHALL select the live redirect by priority trap > mret > branch; addresses trap_vec with bits [1:0] forced to 0, mepc, br_target respectively.
REQ-015 SHALL implement states RUN, PENDING, SHADOW.
REQ-016 In RUN/SHADOW, no freeze, live redirect: count_enb=1, pcsel=1, redirect_addr=selected, flush_ifid=1, flush_idex=1 in the same cycle (combinational); next state SHADOW.
REQ-017 In RUN, no freeze, no redirect, load_use: count_enb=0, stall_ifid=1, flush_idex=1, stall_idex=0; stay RUN.
REQ-018 In RUN, no freeze, no redirect, no load_use: count_enb=1, all other controls 0; stay RUN.
REQ-019 Any state with freeze=1: count_enb=0, stall_ifid=1, stall_idex=1, no flush, pcsel=0.
REQ-020 RUN or SHADOW with freeze and live redirect: latch class and address into pending register; next state PENDING.
REQ-021 In PENDING with freeze: a live redirect of strictly higher priority overwrites the pending one; equal or lower priority is ignored.
REQ-022 In PENDING with freeze=0: count_enb=1, pcsel=1, redirect_addr=latched address, both flushes asserted; a live higher-priority redirect that cycle wins instead; clear pending; next state SHADOW.
REQ-023 In SHADOW with no freeze and no redirect: flush_ifid=1 (squash wrong-path fetch), count_enb=1; next state RUN.
REQ-024 In SHADOW with freeze and no redirect: stay SHADOW; squash is deferred until freeze drops.
REQ-025 Redirect SHALL take priority over load_use in the same cycle.
REQ-026 stall_cnt SHALL increment each cycle count_enb=0; redirect_cnt each cycle pcsel=1; both wrap 0xFFFF_FFFF -> 0.

Reset
REQ-027 On reset, state SHALL be RUN, pending valid 0, pending address 0, stall_cnt 0, redirect_cnt 0, immediately and asynchronously.
REQ-028 Reset mid-PENDING SHALL discard the latched redirect; first post-reset cycle behaves per REQ-018 given quiet inputs.
REQ-029 During reset, outputs SHALL be RUN-state combinational values; PC reset to 0x8000_0000 is owned by the PC.

Structure
REQ-030 Shared package SHALL hold the state enum, redirect-class enum (NONE, BRANCH, MRET, TRAP) and constant PC_RESET_VEC = 0x8000_0000.
REQ-031 Priority selection SHALL be one combinational sub-module redirect_arbiter; FSM, pending register and counters stay in the top.

Verification
REQ-032 br_taken=1, br_target=0x8000_0040, no freeze -> same cycle pcsel=1, addr 0x8000_0040, both flushes; next cycle flush_ifid=1 only; redirect_cnt=1.
REQ-033 load_use=1 for 1 cycle -> count_enb=0, stall_ifid=1, flush_idex=1; stall_cnt=1.
REQ-034 dmem_busy=1 3 cycles, br_taken at cycle 1 (target 0x8000_0100) -> 3 stall cycles, pcsel=1 with 0x8000_0100 on cycle 4, then SHADOW.
REQ-035 PENDING branch 0x8000_0100 then trap_req, trap_vec=0x8000_0203 while frozen -> replay address 0x8000_0200.
REQ-036 trap_req, mret_req, br_taken same cycle -> trap_vec selected; reset asserted in PENDING -> counters 0, no replay after release.
